// File: rtl/sfifo_rd_stream_rd_lat_pipe.sv
// Valid shift register tracking FIFO reads whose data has not yet returned.
// cap_v marks the cycle in which fifo_rdat carries the word of an earlier read.
module rd_lat_pipe #(
    parameter int RD_LAT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       ren,
    output logic       cap_v,
    output logic [1:0] inflight
);

    logic [RD_LAT-1:0] pipe_reg;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            pipe_reg <= '0;
        end else begin
            pipe_reg[0] <= ren;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_reg[i] <= pipe_reg[i-1];
            end
        end
    end

    assign cap_v = pipe_reg[RD_LAT-1];

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + {1'b0, pipe_reg[i]};
        end
    end

endmodule

// File: rtl/sfifo_rd_stream.sv
// Read-side adapter turning the sfifo pull interface into a valid/ready stream.
// A credit-checked circular buffer of RD_LAT+1 entries hides the RAM read latency.
module sfifo_rd_stream #(
    parameter int WIDTH  = 8,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             fifo_empty,
    output logic             fifo_ren,
    input  logic [WIDTH-1:0] fifo_rdat,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [1:0]       buf_cnt
);

    localparam int BUF_DEPTH = RD_LAT + 1;
    localparam int PW        = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

    logic [WIDTH-1:0] buf_mem [BUF_DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [1:0]       buf_cnt_reg;
    logic             pop;
    logic             cap_v;
    logic [1:0]       inflight;
    logic [2:0]       pending;
    logic             credit_ok;

    // Depth can be 3, so the pointers wrap explicitly instead of overflowing.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    rd_lat_pipe #(
        .RD_LAT   (RD_LAT)
    ) u_rd_lat_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .ren      (fifo_ren),
        .cap_v    (cap_v),
        .inflight (inflight)
    );

    assign m_valid = (buf_cnt_reg != 2'd0);
    assign m_data  = buf_mem[rd_ptr_reg];
    assign buf_cnt = buf_cnt_reg;
    assign pop     = m_valid & m_ready;

    // A pop in this cycle frees its entry in time for a read issued now.
    assign pending   = {1'b0, buf_cnt_reg} + {1'b0, inflight};
    assign credit_ok = pending < (3'(BUF_DEPTH) + {2'b00, pop});
    assign fifo_ren  = ~fifo_empty & ~clr & rst_n & credit_ok;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_mem[i] <= '0;
            end
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            buf_cnt_reg <= '0;
        end else begin
            if (cap_v) begin
                buf_mem[wr_ptr_reg] <= fifo_rdat;
                wr_ptr_reg          <= ptr_inc(wr_ptr_reg);
            end
            if (pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            buf_cnt_reg <= buf_cnt_reg + {1'b0, cap_v} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert ({1'b0, buf_cnt_reg} <= 3'(BUF_DEPTH))
                else $error("sfifo_rd_stream buffer overflow: buf_cnt=%0d", buf_cnt_reg);
        end
    end

endmodule

// File: tb/tb_sfifo_rd_stream.sv
// Bench driving RD_LAT=1 and RD_LAT=2 instances side by side against a
// queue-based FIFO/RAM model and an in-order scoreboard.
module tb_sfifo_rd_stream;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] d;
        int           c;
    } ent_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         clr;
    logic         m_ready;
    logic         fifo_empty [2];
    logic         fifo_ren   [2];
    logic         m_valid    [2];
    logic [W-1:0] fifo_rdat  [2];
    logic [W-1:0] m_data     [2];
    logic [1:0]   buf_cnt    [2];

    always #5 clk = ~clk;

    sfifo_rd_stream #(.WIDTH(W), .RD_LAT(1)) u_dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .fifo_empty (fifo_empty[0]),
        .fifo_ren   (fifo_ren[0]),
        .fifo_rdat  (fifo_rdat[0]),
        .m_valid    (m_valid[0]),
        .m_ready    (m_ready),
        .m_data     (m_data[0]),
        .buf_cnt    (buf_cnt[0])
    );

    sfifo_rd_stream #(.WIDTH(W), .RD_LAT(2)) u_dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .fifo_empty (fifo_empty[1]),
        .fifo_ren   (fifo_ren[1]),
        .fifo_rdat  (fifo_rdat[1]),
        .m_valid    (m_valid[1]),
        .m_ready    (m_ready),
        .m_data     (m_data[1]),
        .buf_cnt    (buf_cnt[1])
    );

    // Model state: FIFO contents, words read but not yet delivered, RAM read pipe.
    logic [W-1:0] fq    [2][$];
    ent_t         sb    [2][$];
    ent_t         lat_q [2][$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int ren_cnt  [2];
    int pop_cnt  [2];
    int last_pop [2];
    bit hold_prev [2];
    logic [W-1:0] data_prev [2];
    bit ren_seen [2];
    bit v_seen   [2];
    int cnt_seen [2];
    logic [W-1:0] data_seen [2];
    bit rst_prev = 0;
    bit clr_prev = 0;
    bit armed    = 0;
    bit lat_chk  = 0;
    bit gap_chk  = 0;

    task automatic chk(input string tag, input int k, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s dut%0d got=%0h exp=%0h cyc=%0d", tag, k, obs, exp, cyc);
        end
    endtask

    task automatic clear_counts();
        for (int k = 0; k < 2; k++) begin
            ren_cnt[k] = 0;
            pop_cnt[k] = 0;
        end
    endtask

    task automatic push_word(input logic [W-1:0] d);
        for (int k = 0; k < 2; k++) fq[k].push_back(d);
    endtask

    // One clock cycle: settle FIFO flags, sample mid-cycle, model the edge,
    // then present the RAM read data for the next cycle.
    task automatic step();
        ent_t e;
        bit   pop;
        @(negedge clk);
        for (int k = 0; k < 2; k++) fifo_empty[k] = (fq[k].size() == 0);
        #1;
        for (int k = 0; k < 2; k++) begin
            pop          = 0;
            ren_seen[k]  = fifo_ren[k];
            v_seen[k]    = m_valid[k];
            cnt_seen[k]  = int'(buf_cnt[k]);
            data_seen[k] = m_data[k];
            if (!rst_n) begin
                chk("ren_in_rst", k, int'(fifo_ren[k]), 0);
            end
            if (rst_prev) begin
                chk("rst_valid", k, int'(m_valid[k]), 0);
                chk("rst_data", k, int'(m_data[k]), 0);
                chk("rst_cnt", k, int'(buf_cnt[k]), 0);
            end
            if (rst_n && armed) begin
                if (fifo_empty[k]) chk("ren_empty", k, int'(fifo_ren[k]), 0);
                if (clr) chk("ren_clr", k, int'(fifo_ren[k]), 0);
                chk("cnt_max", k, int'(int'(buf_cnt[k]) <= k + 2), 1);
                chk("valid_cnt", k, int'(m_valid[k]), int'(buf_cnt[k] != 2'd0));
                if (clr_prev) begin
                    chk("clr_valid", k, int'(m_valid[k]), 0);
                    chk("clr_cnt", k, int'(buf_cnt[k]), 0);
                end
                if (hold_prev[k]) begin
                    chk("hold_valid", k, int'(m_valid[k]), 1);
                    chk("hold_data", k, int'(m_data[k]), int'(data_prev[k]));
                end
                pop = m_valid[k] && m_ready;
            end
            if (pop) begin
                if (sb[k].size() == 0) begin
                    chk("pop_unexpected", k, int'(pop), 0);
                end else begin
                    e = sb[k].pop_front();
                    chk("data", k, int'(m_data[k]), int'(e.d));
                    if (lat_chk) chk("latency", k, cyc - e.c, k + 2);
                    if (gap_chk && pop_cnt[k] > 0) chk("gap", k, cyc - last_pop[k], 1);
                end
                $display("dut%0d pop data=%02h cyc=%0d", k, m_data[k], cyc);
                pop_cnt[k]++;
                last_pop[k] = cyc;
            end
            if (fifo_ren[k] && fq[k].size() > 0) begin
                e.d = fq[k].pop_front();
                e.c = cyc;
                sb[k].push_back(e);
                lat_q[k].push_back(e);
                ren_cnt[k]++;
            end else begin
                e.d = W'($urandom);
                e.c = -1;
                lat_q[k].push_back(e);
            end
            if (clr || !rst_n) sb[k].delete();
            hold_prev[k] = rst_n && !clr && m_valid[k] && !m_ready;
            data_prev[k] = m_data[k];
        end
        rst_prev = !rst_n;
        clr_prev = rst_n && clr;
        if (!rst_n) armed = 1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            e = lat_q[k].pop_front();
            fifo_rdat[k] = e.d;
        end
        cyc++;
    endtask

    initial begin
        ent_t e0;
        int   pushed;
        int   guard;
        rst_n   = 1'b0;
        clr     = 1'b0;
        m_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            fifo_empty[k] = 1'b1;
            fifo_rdat[k]  = '0;
            hold_prev[k]  = 0;
            data_prev[k]  = '0;
            last_pop[k]   = 0;
            // RAM read pipe pre-filled so data returns RD_LAT cycles after a read.
            for (int j = 0; j < k; j++) begin
                e0.d = '0;
                e0.c = -1;
                lat_q[k].push_back(e0);
            end
        end
        clear_counts();

        // Reset with a preloaded FIFO, then stream 0x01..0x10.
        for (int i = 1; i <= 16; i++) push_word(W'(i));
        lat_chk = 1;
        gap_chk = 1;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        for (int k = 0; k < 2; k++) chk("ren_after_rst", k, int'(ren_seen[k]), 1);
        for (int j = 1; j <= 3; j++) begin
            step();
            for (int k = 0; k < 2; k++) chk("first_valid", k, int'(v_seen[k]), int'(j >= k + 2));
        end
        repeat (26) step();
        for (int k = 0; k < 2; k++) begin
            chk("stream_ren", k, ren_cnt[k], 16);
            chk("stream_pops", k, pop_cnt[k], 16);
        end

        // Back-pressure: reads stop once the buffer is committed.
        lat_chk = 0;
        gap_chk = 0;
        clear_counts();
        m_ready = 1'b0;
        for (int i = 1; i <= 10; i++) push_word(W'(i));
        repeat (8) step();
        for (int k = 0; k < 2; k++) begin
            chk("bp_ren", k, ren_cnt[k], k + 2);
            chk("bp_cnt", k, cnt_seen[k], k + 2);
            chk("bp_data", k, int'(data_seen[k]), 1);
        end
        m_ready = 1'b1;
        repeat (20) step();
        for (int k = 0; k < 2; k++) chk("bp_pops", k, pop_cnt[k], 10);

        // clr with one word buffered and one in flight on the RD_LAT=2 instance.
        clear_counts();
        m_ready = 1'b0;
        push_word(8'hA1);
        push_word(8'hA2);
        repeat (3) step();
        clr = 1'b1;
        step();
        chk("pre_clr_cnt", 1, cnt_seen[1], 1);
        clr = 1'b0;
        step();
        step();
        for (int k = 0; k < 2; k++) begin
            chk("no_stale_cnt", k, cnt_seen[k], 0);
            chk("no_stale_valid", k, int'(v_seen[k]), 0);
        end
        m_ready = 1'b1;
        push_word(8'hB1);
        push_word(8'hB2);
        push_word(8'hB3);
        repeat (12) step();
        for (int k = 0; k < 2; k++) chk("post_clr_pops", k, pop_cnt[k], 3);

        // Empty toggling: one word per gap, each with first-word latency.
        clear_counts();
        lat_chk = 1;
        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0) push_word(W'(8'hC0 + i / 2));
            step();
        end
        repeat (6) step();
        for (int k = 0; k < 2; k++) chk("toggle_pops", k, pop_cnt[k], 20);

        // Random back-pressure and FIFO fill over 1000 words.
        lat_chk = 0;
        clear_counts();
        pushed = 0;
        guard  = 0;
        while ((pushed < 1000 || fq[0].size() != 0 || fq[1].size() != 0 ||
                sb[0].size() != 0 || sb[1].size() != 0) && guard < 20000) begin
            m_ready = 1'($urandom_range(0, 1));
            if (pushed < 1000 && $urandom_range(0, 3) != 0) begin
                push_word(W'($urandom));
                pushed++;
            end
            step();
            guard++;
        end
        chk("rand_timeout", 0, int'(guard < 20000), 1);
        for (int k = 0; k < 2; k++) chk("rand_pops", k, pop_cnt[k], 1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
